// File: rtl/m_map_stream_tx.sv
// Feature-map transmitter: buffers one frame, then streams it with start qualifier and PAD_VAL tail.
// Optional pad watchdog enabled by defining STREAM_WDOG_EN.
module m_map_stream_tx #(
  parameter int unsigned MAP_LEN    = 9216,
  parameter int unsigned ADDR_W     = 14,
  parameter logic [15:0] PAD_VAL    = 16'd0,
  parameter int unsigned WDOG_LIMIT = 1024
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  input  logic              go,
  input  logic              ready_in,
  output logic [15:0]       map_out,
  output logic              start,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_PRIME, S_STREAM, S_PAD, S_FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [15:0]       rd_data_q;
  logic [15:0]       map_out_q, map_out_d;
  logic              start_q, start_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              fin_q;
  logic              accept;
  logic              wr_ok;
  logic              wdog_hit;
  logic              aborted;

  logic [15:0] mem [0:(2**ADDR_W)-1];

  assign accept = (state_q == S_IDLE) && go && ready_in;
  assign wr_ok  = (state_q == S_IDLE) && wr_en && ({1'b0, wr_addr} < CNT_W'(MAP_LEN));

  always_ff @(posedge clk_in) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
    rd_data_q <= mem[rd_addr_q];
  end

`ifdef STREAM_WDOG_EN
  localparam int unsigned WD_W = $clog2(WDOG_LIMIT + 1);
  logic [WD_W-1:0] pad_cnt_q;
  logic            abort_q;
  logic            err_q;

  assign wdog_hit = (state_q == S_PAD) && ready_in && (pad_cnt_q == WD_W'(WDOG_LIMIT - 1));
  assign aborted  = abort_q;
  assign err      = err_q;

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      pad_cnt_q <= '0;
      abort_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      pad_cnt_q <= (state_q == S_PAD) ? pad_cnt_q + 1'b1 : '0;
      if (accept)        abort_q <= 1'b0;
      else if (wdog_hit) abort_q <= 1'b1;
      // err is raised together with the start drop so it lines up with the missing done
      if (accept)                              err_q <= 1'b0;
      else if ((state_q == S_FINISH) && abort_q) err_q <= 1'b1;
    end
  end
`else
  assign wdog_hit = 1'b0;
  assign aborted  = 1'b0;
  assign err      = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    pix_cnt_d = pix_cnt_q;
    rd_addr_d = rd_addr_q;
    map_out_d = '0;
    start_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        pix_cnt_d = '0;
        if (accept) begin
          rd_addr_d = '0;
          state_d   = S_PRIME;
        end
      end
      S_PRIME: begin
        rd_addr_d = rd_addr_q + 1'b1;
        state_d   = S_STREAM;
      end
      S_STREAM: begin
        start_d   = 1'b1;
        map_out_d = rd_data_q;
        rd_addr_d = rd_addr_q + 1'b1;
        pix_cnt_d = pix_cnt_q + 1'b1;
        if (!ready_in)                               state_d = S_FINISH;
        else if (pix_cnt_q == CNT_W'(MAP_LEN - 1))   state_d = S_PAD;
      end
      S_PAD: begin
        start_d   = 1'b1;
        map_out_d = PAD_VAL;
        if (!ready_in || wdog_hit) state_d = S_FINISH;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are registered one stage behind the state, so busy clears a cycle after FINISH
  always_comb begin
    busy_d = busy_q;
    if (accept)     busy_d = 1'b1;
    else if (fin_q) busy_d = 1'b0;
    done_d = (state_q == S_FINISH) && !aborted;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pix_cnt_q <= '0;
      rd_addr_q <= '0;
      map_out_q <= '0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fin_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pix_cnt_q <= pix_cnt_d;
      rd_addr_q <= rd_addr_d;
      map_out_q <= map_out_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      fin_q     <= (state_q == S_FINISH);
    end
  end

  assign map_out = map_out_q;
  assign start   = start_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_m_map_stream_tx.sv
// Self-checking bench for m_map_stream_tx: vector table, directed corner sequences, random frames.
module tb_m_map_stream_tx;

  localparam int unsigned MAP_LEN    = 16;
  localparam int unsigned ADDR_W     = 5;
  localparam logic [15:0] PAD_VAL    = 16'h7FFF;
  localparam int unsigned WDOG_LIMIT = 8;

  logic              clk_in = 1'b0;
  logic              rst_n;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic              go;
  logic              ready_in;
  logic [15:0]       map_out;
  logic              start;
  logic              busy;
  logic              done;
  logic              err;

  m_map_stream_tx #(
    .MAP_LEN(MAP_LEN), .ADDR_W(ADDR_W), .PAD_VAL(PAD_VAL), .WDOG_LIMIT(WDOG_LIMIT)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .go(go), .ready_in(ready_in), .map_out(map_out), .start(start), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk_in = ~clk_in;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [15:0] ref_mem [0:MAP_LEN-1];

  typedef struct {
    logic              rst_n;
    logic              wr_en;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
    logic              go;
    logic              ready;
    logic              e_start;
    logic              e_busy;
    logic              e_done;
    logic [15:0]       e_map;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_out(input string tag, input logic e_start, input logic [15:0] e_map,
                           input logic e_busy, input logic e_done, input logic e_err);
    chk({tag, ".start"}, start, e_start);
    chk({tag, ".map_out"}, map_out, e_map);
    chk({tag, ".busy"}, busy, e_busy);
    chk({tag, ".done"}, done, e_done);
    chk({tag, ".err"}, err, e_err);
  endtask

  // Word w of a frame: buffered pixel while w < MAP_LEN, pad word afterwards
  function automatic logic [15:0] exp_word(input int unsigned w);
    return (w < MAP_LEN) ? ref_mem[w] : PAD_VAL;
  endfunction

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
    if (a < MAP_LEN) ref_mem[a] = d;
  endtask

  task automatic accept_go(input bit with_wr, input logic [ADDR_W-1:0] a, input logic [15:0] d);
    go = 1'b1; ready_in = 1'b1; wr_en = with_wr; wr_addr = a; wr_data = d;
    tick();
    go = 1'b0; wr_en = 1'b0;
    if (with_wr && a < MAP_LEN) ref_mem[a] = d;
    check_out("accept", 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    tick();
    check_out("prime", 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
  endtask

  // Observes words first_w..n_words-1; with drop, ready falls on the edge that emits the last one
  task automatic stream_check(input int unsigned first_w, input int unsigned n_words,
                              input bit drop, input bit exp_abort);
    for (int unsigned w = first_w; w < n_words; w++) begin
      if (drop && w == n_words - 1) ready_in = 1'b0;
      wr_en = 1'($urandom_range(0, 1)); wr_addr = ADDR_W'($urandom); wr_data = 16'($urandom);
      tick();
      check_out($sformatf("word%0d", w), 1'b1, exp_word(w), 1'b1, 1'b0, 1'b0);
    end
    wr_en = 1'b0;
    tick();
    check_out("finish", 1'b0, 16'h0, 1'b1, !exp_abort, exp_abort);
    tick();
    check_out("idle", 1'b0, 16'h0, 1'b0, 1'b0, exp_abort);
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; go = 1'b0; ready_in = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    for (int unsigned i = 0; i < MAP_LEN; i++) do_write(ADDR_W'(i), 16'(i + 100));

    // Reset (buffer kept), out-of-range write, go blocked by ready=0, acceptance, first words
    tbl[0] = '{1'b0, 1'b0, 5'd0,  16'h0,    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0};
    tbl[1] = '{1'b1, 1'b1, 5'd20, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0};
    tbl[2] = '{1'b1, 1'b0, 5'd0,  16'h0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0};
    tbl[3] = '{1'b1, 1'b0, 5'd0,  16'h0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0};
    tbl[4] = '{1'b1, 1'b0, 5'd0,  16'h0,    1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0};
    tbl[5] = '{1'b1, 1'b0, 5'd0,  16'h0,    1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0};
    tbl[6] = '{1'b1, 1'b0, 5'd0,  16'h0,    1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd100};
    tbl[7] = '{1'b1, 1'b0, 5'd0,  16'h0,    1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd101};
    tbl[8] = '{1'b1, 1'b0, 5'd0,  16'h0,    1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'd102};
    tbl[9] = '{1'b1, 1'b1, 5'd3,  16'hBEEF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd103};
    for (int unsigned r = 0; r < 10; r++) begin
      rst_n = tbl[r].rst_n; wr_en = tbl[r].wr_en; wr_addr = tbl[r].addr;
      wr_data = tbl[r].data; go = tbl[r].go; ready_in = tbl[r].ready;
      tick();
      check_out($sformatf("tbl%0d", r), tbl[r].e_start, tbl[r].e_map, tbl[r].e_busy,
                tbl[r].e_done, 1'b0);
    end
    go = 1'b0; wr_en = 1'b0;
    // Rest of the frame with exactly five pad words before ready falls
    stream_check(4, MAP_LEN + 5, 1'b1, 1'b0);

    // Second frame: word 3 unchanged by the write during STREAM; ready falls on the last pixel
    accept_go(1'b0, '0, '0);
    stream_check(0, MAP_LEN, 1'b1, 1'b0);

    // Reset at pixel 7, then restart from pixel 0
    accept_go(1'b0, '0, '0);
    for (int unsigned w = 0; w < 8; w++) begin
      tick();
      check_out($sformatf("pre_rst%0d", w), 1'b1, exp_word(w), 1'b1, 1'b0, 1'b0);
    end
    rst_n = 1'b0;
    tick();
    check_out("mid_rst", 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    check_out("post_rst", 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    accept_go(1'b0, '0, '0);
    stream_check(0, MAP_LEN + 1, 1'b1, 1'b0);

    // ready held high through PAD
    accept_go(1'b0, '0, '0);
`ifdef STREAM_WDOG_EN
    stream_check(0, MAP_LEN + WDOG_LIMIT, 1'b0, 1'b1);
    accept_go(1'b0, '0, '0);
    stream_check(0, 3, 1'b1, 1'b0);
`else
    stream_check(0, MAP_LEN + 3 * WDOG_LIMIT, 1'b1, 1'b0);
`endif

    // Random frames against the buffer model
    for (int unsigned f = 0; f < 8; f++) begin
      ready_in = 1'b1;
      for (int unsigned k = 0; k < 6; k++)
        do_write(ADDR_W'($urandom_range(0, 31)), 16'($urandom));
      accept_go(1'b1, ADDR_W'($urandom_range(0, MAP_LEN - 1)), 16'($urandom));
      stream_check(0, $urandom_range(1, MAP_LEN + WDOG_LIMIT), 1'b1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/m_map_stream_tx.md
Name: m_map_stream_tx

Overview:
- Feature-map transmitter that feeds a convolution layer's streaming input (map_in/start) and watches that layer's ready/done indication.
- A feature map is loaded into an internal single-port-write / registered-read buffer. On go, the block asserts start and streams one 16-bit word per clock in raster order.
- After the last pixel it pads with PAD_VAL, holding start high until the downstream layer deasserts ready (all outputs produced). It then drops start and reports done.
- Sits between a layer's result buffer (or the input image loader) and the next m_conv_* stage.

Parameters:
- MAP_LEN, 9216, number of valid pixels streamed per frame (96x96).
- ADDR_W, 14, buffer address width; 2**ADDR_W >= MAP_LEN.
- PAD_VAL, 16'd0, word driven on map_out after the last pixel while waiting for ready to fall.
- WDOG_LIMIT, 1024, maximum pad cycles before abort (used only with STREAM_WDOG_EN).

Ports:
- clk_in  input  1  clock, all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- wr_en  input  1  buffer write strobe; honoured only in IDLE.
- wr_addr  input  ADDR_W  buffer write address.
- wr_data  input  16  signed pixel to store.
- go  input  1  request to transmit the buffered frame; level or pulse.
- ready_in  input  1  downstream ready: 1 = still accepting / computing, 0 = frame finished.
- map_out  output  16  signed pixel stream to downstream map_in.
- start  output  1  stream-active qualifier to downstream.
- busy  output  1  high from go acceptance until return to IDLE.
- done  output  1  one-cycle pulse when a frame completes normally.
- err  output  1  sticky abort flag (STREAM_WDOG_EN only; tied 0 otherwise).

Behaviour:
- Reset (rst_n=0 at a clock edge): map_out=0, start=0, busy=0, done=0, err=0, FSM=IDLE, counters=0. Buffer contents are not cleared.
- Reset mid-frame: start and busy go to 0 at that edge, with no done pulse. After reset, the next go restarts from pixel 0.
- IDLE:
  - wr_en writes wr_data to mem[wr_addr]; out-of-range addresses (>= MAP_LEN) are dropped.
  - Leave IDLE only when go=1 AND ready_in=1 on the same edge. If go=1 with ready_in=0, stay in IDLE and do nothing; go is not latched.
  - Accepting go sets busy=1, issues read address 0 and moves to PRIME.
- PRIME: one cycle for the registered read. Issue address 1. Move to STREAM.
- STREAM:
  - start=1. map_out = mem[k] on the k-th start cycle (k = 0 .. MAP_LEN-1). Read address runs one ahead.
  - Pixel counter is ADDR_W+1 bits wide. After word MAP_LEN-1 is driven, move to PAD.
  - If ready_in falls during STREAM (early finish), go directly to FINISH.
- PAD: start=1, map_out=PAD_VAL. Stay until ready_in=0 is sampled, then move to FINISH.
- FINISH: start=0, map_out=0, done=1 for exactly this cycle. Next state is IDLE; busy=0 in the IDLE cycle.
- Latency: go accepted at edge N gives start=1 with mem[0] from edge N+2. ready_in=0 sampled at edge M gives start=0 at edge M+1.
- wr_en outside IDLE is ignored, and go outside IDLE is ignored. A write in IDLE on the same edge as go acceptance is performed.
- There is no back-pressure within a frame: exactly one word per clock while start=1.
- Words are stored and streamed unmodified; there is no arithmetic on data.

Optional Feature:
- Macro STREAM_WDOG_EN.
- Defined: a pad-cycle counter runs in PAD. If it reaches WDOG_LIMIT with ready_in still 1, go to FINISH with done=0 and set err=1. err stays set until reset or the next accepted go.
- Undefined: PAD waits indefinitely, and err is constant 0.

Test Plan (bench uses MAP_LEN=16, ADDR_W=5, PAD_VAL=16'h7FFF, WDOG_LIMIT=8):
- Load mem[i]=i+100 for i=0..15, go=1 with ready_in=1 -> start rises 2 cycles later; map_out = 100..115 on 16 consecutive cycles, then 16'h7FFF; busy=1 throughout.
- ready_in driven to 0 five cycles into PAD -> start=0 one cycle later, done pulses exactly once, busy=0 the following cycle; the PAD count (5) is visible.
- go=1 while ready_in=0 -> no start, busy stays 0. Raising ready_in with go still 1 -> frame starts normally.
- wr_en to addr 3 with data 16'hBEEF during STREAM, then a second frame -> word 3 still reads 103. Write of addr 20 in IDLE -> no effect.
- rst_n=0 at pixel 7 -> start/busy/map_out=0 next edge, no done. Re-go after reset -> stream restarts at 100.
- With STREAM_WDOG_EN, ready_in held 1 -> after 8 PAD cycles start=0, err=1, done=0. The next go clears err. Without the macro -> start stays 1 indefinitely and err=0.
